sar_adc_ctrl_avg: RTL

Parametrised, fully synchronous successor to the 12/14-bit asynchronous SAR controller. It runs an N-bit successive-approximation search against an external comparator using a four-phase fire/done handshake, and guards every trial with a cycle timeout. It can average 2^AVG_LOG2 back-to-back conversions per start request. It sits between the sampling switch/DAC array and the digital back end, and replaces the self-timed clkout/clkin loop with a single system clock.

---
 rtl/sar_adc_ctrl_avg.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/sar_adc_ctrl_avg.sv
// Synchronous N-bit SAR conversion controller with per-phase comparator timeout
// and 2^AVG_LOG2-sample averaging of back-to-back conversions.
module sar_adc_ctrl_avg #(
    parameter int WIDTH      = 12,
    parameter int AVG_LOG2   = 2,
    parameter int SAMPLE_CYC = 2,
    parameter int TIMEOUT    = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             st_conv,
    input  logic             comp_done,
    input  logic             comp_in,
    output logic             sample,
    output logic             fire_comp,
    output logic [WIDTH-1:0] dac_value,
    output logic [WIDTH-1:0] result,
    output logic             adc_done,
    output logic             busy,
    output logic             timeout_err
);

    localparam int ACC_W  = WIDTH + AVG_LOG2;
    localparam int BIT_W  = $clog2(WIDTH);
    localparam int CONV_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int SAMP_W = $clog2(SAMPLE_CYC + 1);
    localparam int TO_W   = $clog2(TIMEOUT + 1);

    localparam logic [CONV_W-1:0] CONV_LAST = CONV_W'((1 << AVG_LOG2) - 1);
    localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(SAMPLE_CYC - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);
    localparam logic [BIT_W-1:0]  BIT_MSB   = BIT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0]  MSB_MASK  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAMPLE,
        S_TRIAL,
        S_RELEASE,
        S_NEXT,
        S_DONE
    } state_t;

    state_t              state_reg;
    logic [WIDTH-1:0]    code_reg;
    logic [BIT_W-1:0]    bit_idx_reg;
    logic [ACC_W-1:0]    acc_reg;
    logic [CONV_W-1:0]   conv_cnt_reg;
    logic [SAMP_W-1:0]   samp_cnt_reg;
    logic [TO_W-1:0]     to_cnt_reg;

    logic [WIDTH-1:0]    trial_mask;
    logic [WIDTH-1:0]    code_next;
    logic [ACC_W-1:0]    acc_sum;
    logic                phase_to;
    logic                last_conv;

    // One-hot decode of the bit currently under trial.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_mask
            assign trial_mask[gi] = (bit_idx_reg == BIT_W'(gi));
        end
    endgenerate

    // A timed-out trial has comp_done low, so the bit is dropped automatically.
    assign code_next = (comp_done && comp_in) ? (code_reg | trial_mask) : code_reg;
    assign acc_sum   = acc_reg + ACC_W'(code_reg);
    assign phase_to  = (to_cnt_reg == TO_LAST);
    assign last_conv = (conv_cnt_reg == CONV_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            code_reg     <= '0;
            bit_idx_reg  <= '0;
            acc_reg      <= '0;
            conv_cnt_reg <= '0;
            samp_cnt_reg <= '0;
            to_cnt_reg   <= '0;
            sample       <= 1'b0;
            fire_comp    <= 1'b0;
            dac_value    <= '0;
            result       <= '0;
            adc_done     <= 1'b0;
            busy         <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            adc_done <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (st_conv) begin
                        state_reg    <= S_SAMPLE;
                        busy         <= 1'b1;
                        sample       <= 1'b1;
                        dac_value    <= '0;
                        acc_reg      <= '0;
                        conv_cnt_reg <= '0;
                        samp_cnt_reg <= '0;
                        timeout_err  <= 1'b0;
                    end
                end

                S_SAMPLE: begin
                    code_reg    <= '0;
                    bit_idx_reg <= BIT_MSB;
                    if (samp_cnt_reg == SAMP_LAST) begin
                        state_reg  <= S_TRIAL;
                        sample     <= 1'b0;
                        fire_comp  <= 1'b1;
                        dac_value  <= MSB_MASK;
                        to_cnt_reg <= '0;
                    end else begin
                        samp_cnt_reg <= samp_cnt_reg + 1'b1;
                    end
                end

                S_TRIAL: begin
                    if (comp_done || phase_to) begin
                        state_reg  <= S_RELEASE;
                        fire_comp  <= 1'b0;
                        code_reg   <= code_next;
                        dac_value  <= code_next;
                        to_cnt_reg <= '0;
                        if (!comp_done) begin
                            timeout_err <= 1'b1;
                        end
                    end else begin
                        to_cnt_reg <= to_cnt_reg + 1'b1;
                    end
                end

                // The bit-step half of NEXT is folded in here so each bit costs 4 cycles.
                S_RELEASE: begin
                    if (!comp_done || phase_to) begin
                        if (comp_done) begin
                            timeout_err <= 1'b1;
                        end
                        if (bit_idx_reg != '0) begin
                            bit_idx_reg <= bit_idx_reg - 1'b1;
                            state_reg   <= S_TRIAL;
                            fire_comp   <= 1'b1;
                            dac_value   <= code_reg | (trial_mask >> 1);
                            to_cnt_reg  <= '0;
                        end else begin
                            state_reg <= S_NEXT;
                        end
                    end else begin
                        to_cnt_reg <= to_cnt_reg + 1'b1;
                    end
                end

                S_NEXT: begin
                    acc_reg <= acc_sum;
                    if (last_conv) begin
                        state_reg <= S_DONE;
                        result    <= acc_sum[ACC_W-1 -: WIDTH];
                        adc_done  <= 1'b1;
                    end else begin
                        conv_cnt_reg <= conv_cnt_reg + 1'b1;
                        state_reg    <= S_SAMPLE;
                        sample       <= 1'b1;
                        dac_value    <= '0;
                        samp_cnt_reg <= '0;
                    end
                end

                S_DONE: begin
                    state_reg <= S_IDLE;
                    busy      <= 1'b0;
                end

                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule
